// File: rtl/matrix_pkg.sv
// Shared constants, FSM state type and packed-element select for the 3x3 matrix datapath.
package matrix_pkg;

   localparam int EW        = 8;
   localparam int DIM       = 3;
   localparam int PACK_W    = 72;
   localparam int ACC_W_DEF = 18;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READY = 2'd1,
      MAC   = 2'd2,
      OUT   = 2'd3
   } state_t;

   // Element k of a packed vector; element 0 occupies the top byte.
   function automatic logic [EW-1:0] elem(input logic [PACK_W-1:0] v, input logic [3:0] k);
      return v[(PACK_W-1) - EW*int'(k) -: EW];
   endfunction

endpackage

// File: rtl/mac_unit.sv
// Registered multiply-accumulate with synchronous clear and enable.
// MAT_VEC_MAC_SIGNED_EN selects two's-complement operands; otherwise unsigned.
module mac_unit #(
   parameter int DW    = 8,
   parameter int ACC_W = 18
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_i,
   input  logic             en_i,
   input  logic [DW-1:0]    a_i,
   input  logic [DW-1:0]    b_i,
   output logic [ACC_W-1:0] acc_o
);

   logic [ACC_W-1:0] prod_ext;
   logic [ACC_W-1:0] acc_q, acc_d;

`ifdef MAT_VEC_MAC_SIGNED_EN
   logic signed [2*DW-1:0] prod;
   assign prod     = $signed(a_i) * $signed(b_i);
   assign prod_ext = {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};
`else
   logic [2*DW-1:0] prod;
   assign prod     = a_i * b_i;
   assign prod_ext = {{(ACC_W-2*DW){1'b0}}, prod};
`endif

   always_comb begin
      acc_d = acc_q;
      if (clr_i) begin
         acc_d = '0;
      end else if (en_i) begin
         acc_d = acc_q + prod_ext;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign acc_o = acc_q;

endmodule

// File: rtl/mat_vec_mac.sv
// y = A*b engine: one MAC per clock, row results streamed out over valid/ready.
// MAT_VEC_MAC_SIGNED_EN (in mac_unit) switches to signed arithmetic.
//
//   state | meaning
//   IDLE  | no A matrix loaded yet, waiting for first promotion
//   READY | A loaded, accepting a B vector (or promoting a pending A)
//   MAC   | accumulating a[row][col]*b[col], one column per clock
//   OUT   | row result presented, waiting for res_ready
module mat_vec_mac
   import matrix_pkg::*;
#(
   parameter int DW    = EW,
   parameter int ACC_W = ACC_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_A_done,
   input  logic [PACK_W-1:0] A_input,
   input  logic              b_valid,
   input  logic [3*EW-1:0]   b_data,
   output logic              b_ready,
   output logic              res_valid,
   output logic [ACC_W-1:0]  res_data,
   output logic [1:0]        res_row,
   input  logic              res_ready,
   output logic              busy
);

   state_t            state_q, state_d;
   logic              ld_q;
   logic [PACK_W-1:0] a_shadow_q, a_active_q;
   logic              a_loaded_q, a_pending_q;
   logic [3*EW-1:0]   b_q, b_d;
   logic [1:0]        row_q, row_d;
   logic [1:0]        col_q, col_d;
   logic              promote, acc_clr, acc_en;
   logic [3:0]        a_idx;
   logic [EW-1:0]     a_el, b_el;

   // A new load during promotion keeps a_pending set, so the newer shadow is promoted next cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ld_q        <= 1'b0;
         a_shadow_q  <= '0;
         a_active_q  <= '0;
         a_loaded_q  <= 1'b0;
         a_pending_q <= 1'b0;
      end else begin
         ld_q <= load_A_done;
         if (ld_q) begin
            a_shadow_q <= A_input;
         end
         if (promote) begin
            a_active_q <= a_shadow_q;
            a_loaded_q <= 1'b1;
         end
         if (ld_q) begin
            a_pending_q <= 1'b1;
         end else if (promote) begin
            a_pending_q <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         b_q     <= '0;
         row_q   <= '0;
         col_q   <= '0;
      end else begin
         state_q <= state_d;
         b_q     <= b_d;
         row_q   <= row_d;
         col_q   <= col_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      b_d       = b_q;
      row_d     = row_q;
      col_d     = col_q;
      promote   = 1'b0;
      acc_clr   = 1'b0;
      acc_en    = 1'b0;
      b_ready   = 1'b0;
      res_valid = 1'b0;
      busy      = 1'b0;
      case (state_q)
         IDLE: begin
            if (a_pending_q) begin
               promote = 1'b1;
               state_d = READY;
            end
         end
         READY: begin
            b_ready = a_loaded_q & ~a_pending_q;
            if (a_pending_q) begin
               promote = 1'b1;
            end else if (b_valid && b_ready) begin
               b_d     = b_data;
               acc_clr = 1'b1;
               row_d   = 2'd0;
               col_d   = 2'd0;
               state_d = MAC;
            end
         end
         MAC: begin
            busy   = 1'b1;
            acc_en = 1'b1;
            if (col_q == 2'(DIM-1)) begin
               col_d   = 2'd0;
               state_d = OUT;
            end else begin
               col_d = col_q + 2'd1;
            end
         end
         OUT: begin
            busy      = 1'b1;
            res_valid = 1'b1;
            if (res_ready) begin
               if (row_q < 2'(DIM-1)) begin
                  row_d   = row_q + 2'd1;
                  col_d   = 2'd0;
                  acc_clr = 1'b1;
                  state_d = MAC;
               end else begin
                  state_d = READY;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign a_idx = 4'(row_q) * 4'd3 + 4'(col_q);
   assign a_el  = elem(a_active_q, a_idx);
   // b occupies the bottom three element slots once zero-padded to the packed width.
   assign b_el  = elem({{(PACK_W-3*EW){1'b0}}, b_q}, 4'(col_q) + 4'd6);

   mac_unit #(
      .DW    (DW),
      .ACC_W (ACC_W)
   ) u_mac (
      .clk   (clk),
      .rst   (rst),
      .clr_i (acc_clr),
      .en_i  (acc_en),
      .a_i   (a_el),
      .b_i   (b_el),
      .acc_o (res_data)
   );

   assign res_row = row_q;

endmodule

// File: tb/tb_mat_vec_mac.sv
// Self-checking bench for mat_vec_mac against a plain-arithmetic y = A*b model.
module tb_mat_vec_mac;

   localparam int ACC_W = 18;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              load_A_done = 1'b0;
   logic [71:0]       A_input = '0;
   logic              b_valid = 1'b0;
   logic [23:0]       b_data = '0;
   logic              b_ready;
   logic              res_valid;
   logic [ACC_W-1:0]  res_data;
   logic [1:0]        res_row;
   logic              res_ready = 1'b0;
   logic              busy;

   int n_checks = 0;
   int n_fail   = 0;

   logic [ACC_W-1:0]  got_data[3];
   logic [1:0]        got_row[3];
   int                got_lat;
   bit                got_timeout;
   logic [ACC_W-1:0]  hold_data[5];
   logic [1:0]        hold_row[5];
   logic              hold_valid[5];
   logic              hold_bready[5];

   mat_vec_mac dut (
      .clk         (clk),
      .rst         (rst),
      .load_A_done (load_A_done),
      .A_input     (A_input),
      .b_valid     (b_valid),
      .b_data      (b_data),
      .b_ready     (b_ready),
      .res_valid   (res_valid),
      .res_data    (res_data),
      .res_row     (res_row),
      .res_ready   (res_ready),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got time %0t required less", $time);
      $fatal(1);
   end

   function automatic logic [ACC_W-1:0] model_row(input logic [71:0] am, input logic [23:0] bv,
                                                  input int r);
      int sum = 0;
      int ea, eb;
      logic [7:0] ba, bb;
      for (int c = 0; c < 3; c++) begin
         ba = am[71 - 8*(3*r + c) -: 8];
         bb = bv[23 - 8*c -: 8];
`ifdef MAT_VEC_MAC_SIGNED_EN
         ea = int'($signed(ba));
         eb = int'($signed(bb));
`else
         ea = int'(ba);
         eb = int'(bb);
`endif
         sum += ea * eb;
      end
      return sum[ACC_W-1:0];
   endfunction

   task automatic load_a(input logic [71:0] a);
      A_input     = a;
      load_A_done = 1'b1;
      @(negedge clk);
      load_A_done = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic send_vector(input logic [23:0] b, output bit ok);
      int n = 0;
      while (!b_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      ok = b_ready;
      if (ok) begin
         b_valid = 1'b1;
         b_data  = b;
         @(negedge clk);
         b_valid = 1'b0;
      end
   endtask

   // mode 0: res_ready held high; mode 1: random. hold_r: row stalled for 5 cycles (-1 = none).
   task automatic collect(input int mode, input int hold_r);
      int cyc = 0;
      int k = 0;
      int held = 0;
      got_lat = -1;
      while (k < 3 && cyc < 300) begin
         if (res_valid && got_lat < 0) got_lat = cyc;
         if ((held > 0 && held < 5) || (held == 0 && res_valid && int'(res_row) == hold_r)) begin
            res_ready         = 1'b0;
            hold_data[held]   = res_data;
            hold_row[held]    = res_row;
            hold_valid[held]  = res_valid;
            hold_bready[held] = b_ready;
            held++;
         end else begin
            res_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         end
         if (res_valid && res_ready) begin
            got_data[k] = res_data;
            got_row[k]  = res_row;
            k++;
         end
         @(negedge clk);
         cyc++;
      end
      res_ready   = 1'b0;
      got_timeout = (k < 3);
   endtask

   task automatic test_reset();
      #1 rst = 1'b0;
      #1;
      n_checks++; if (b_ready !== 1'b0) begin n_fail++; $display("FAIL reset_b_ready got %b want 0", b_ready); end
      n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid got %b want 0", res_valid); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
      n_checks++; if (res_data !== '0) begin n_fail++; $display("FAIL reset_res_data got %0h want 0", res_data); end
      n_checks++; if (res_row !== 2'd0) begin n_fail++; $display("FAIL reset_res_row got %0d want 0", res_row); end
      @(negedge clk);
      rst = 1'b1;
      repeat (4) @(negedge clk);
      n_checks++; if (b_ready !== 1'b0) begin n_fail++; $display("FAIL idle_no_a_b_ready got %b want 0", b_ready); end
   endtask

   task automatic test_identity();
      bit ok;
      logic [ACC_W-1:0] exp[3];
      exp[0] = 18'd3; exp[1] = 18'd5; exp[2] = 18'd7;
      load_a(72'h010000000100000001);
      send_vector(24'h030507, ok);
      n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL ident_accept got b_ready %b want 1", ok); end
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ident_busy got %b want 1", busy); end
      n_checks++; if (b_ready !== 1'b0) begin n_fail++; $display("FAIL ident_b_ready_mac got %b want 0", b_ready); end
      collect(0, -1);
      n_checks++; if (got_timeout !== 1'b0) begin n_fail++; $display("FAIL ident_timeout got %b want 0", got_timeout); end
      n_checks++; if (got_lat !== 3) begin n_fail++; $display("FAIL ident_latency got %0d want 3", got_lat); end
      for (int r = 0; r < 3; r++) begin
         n_checks++; if (got_data[r] !== exp[r]) begin n_fail++; $display("FAIL ident_row%0d_data got %0d want %0d", r, got_data[r], exp[r]); end
         n_checks++; if (got_row[r] !== 2'(r)) begin n_fail++; $display("FAIL ident_row%0d_idx got %0d want %0d", r, got_row[r], r); end
      end
   endtask

   task automatic test_all_ones();
      bit ok;
      logic [ACC_W-1:0] exp;
`ifdef MAT_VEC_MAC_SIGNED_EN
      exp = 18'd3;
`else
      exp = 18'd195075;
`endif
      load_a({9{8'hFF}});
      send_vector(24'hFFFFFF, ok);
      collect(0, -1);
      n_checks++; if (got_timeout !== 1'b0) begin n_fail++; $display("FAIL ones_timeout got %b want 0", got_timeout); end
      for (int r = 0; r < 3; r++) begin
         n_checks++; if (got_data[r] !== exp) begin n_fail++; $display("FAIL ones_row%0d got %0h want %0h", r, got_data[r], exp); end
      end
   endtask

   task automatic test_backpressure();
      bit ok;
      logic [71:0] a = 72'h0102030405060708_09;
      logic [23:0] b = 24'h0A0B0C;
      load_a(a);
      send_vector(b, ok);
      collect(0, 1);
      n_checks++; if (got_timeout !== 1'b0) begin n_fail++; $display("FAIL bp_timeout got %b want 0", got_timeout); end
      for (int i = 0; i < 5; i++) begin
         n_checks++; if (hold_valid[i] !== 1'b1) begin n_fail++; $display("FAIL bp_valid_c%0d got %b want 1", i, hold_valid[i]); end
         n_checks++; if (hold_data[i] !== model_row(a, b, 1)) begin n_fail++; $display("FAIL bp_data_c%0d got %0d want %0d", i, hold_data[i], model_row(a, b, 1)); end
         n_checks++; if (hold_row[i] !== 2'd1) begin n_fail++; $display("FAIL bp_row_c%0d got %0d want 1", i, hold_row[i]); end
         n_checks++; if (hold_bready[i] !== 1'b0) begin n_fail++; $display("FAIL bp_b_ready_c%0d got %b want 0", i, hold_bready[i]); end
      end
      for (int r = 0; r < 3; r++) begin
         n_checks++; if (got_data[r] !== model_row(a, b, r)) begin n_fail++; $display("FAIL bp_row%0d_data got %0d want %0d", r, got_data[r], model_row(a, b, r)); end
         n_checks++; if (got_row[r] !== 2'(r)) begin n_fail++; $display("FAIL bp_row%0d_idx got %0d want %0d", r, got_row[r], r); end
      end
   endtask

   task automatic test_reload_mid_vector();
      bit ok;
      logic [71:0] a_old = 72'h010000000100000001;
      logic [23:0] b = 24'($urandom);
      load_a(a_old);
      send_vector(b, ok);
      fork
         collect(0, -1);
         begin
            A_input     = {9{8'h02}};
            load_A_done = 1'b1;
            @(negedge clk);
            load_A_done = 1'b0;
         end
      join
      n_checks++; if (got_timeout !== 1'b0) begin n_fail++; $display("FAIL reload_timeout got %b want 0", got_timeout); end
      for (int r = 0; r < 3; r++) begin
         n_checks++; if (got_data[r] !== model_row(a_old, b, r)) begin n_fail++; $display("FAIL reload_old_row%0d got %0d want %0d", r, got_data[r], model_row(a_old, b, r)); end
      end
      n_checks++; if (b_ready !== 1'b0) begin n_fail++; $display("FAIL reload_promote_b_ready got %b want 0", b_ready); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reload_promote_busy got %b want 0", busy); end
      @(negedge clk);
      n_checks++; if (b_ready !== 1'b1) begin n_fail++; $display("FAIL reload_after_b_ready got %b want 1", b_ready); end
      send_vector(24'h010101, ok);
      collect(0, -1);
      for (int r = 0; r < 3; r++) begin
         n_checks++; if (got_data[r] !== 18'd6) begin n_fail++; $display("FAIL reload_new_row%0d got %0d want 6", r, got_data[r]); end
      end
   endtask

   task automatic test_random();
      bit ok;
      logic [95:0] t;
      logic [71:0] a;
      logic [23:0] b;
      for (int v = 0; v < 8; v++) begin
         t = {$urandom, $urandom, $urandom};
         a = t[71:0];
         b = 24'($urandom);
         load_a(a);
         send_vector(b, ok);
         collect(1, -1);
         n_checks++; if (got_timeout !== 1'b0) begin n_fail++; $display("FAIL rand%0d_timeout got %b want 0", v, got_timeout); end
         for (int r = 0; r < 3; r++) begin
            n_checks++; if (got_data[r] !== model_row(a, b, r)) begin n_fail++; $display("FAIL rand%0d_row%0d got %0d want %0d", v, r, got_data[r], model_row(a, b, r)); end
            n_checks++; if (got_row[r] !== 2'(r)) begin n_fail++; $display("FAIL rand%0d_idx%0d got %0d want %0d", v, r, got_row[r], r); end
         end
      end
   endtask

   task automatic test_signed();
      bit ok;
      logic [ACC_W-1:0] exp;
      load_a({9{8'h80}});
      send_vector(24'h808080, ok);
      collect(0, -1);
      for (int r = 0; r < 3; r++) begin
         n_checks++; if (got_data[r] !== 18'd49152) begin n_fail++; $display("FAIL sgn80_row%0d got %0d want 49152", r, got_data[r]); end
      end
`ifdef MAT_VEC_MAC_SIGNED_EN
      exp = 18'h3FFFD;
`else
      exp = 18'd765;
`endif
      load_a({9{8'hFF}});
      send_vector(24'h010101, ok);
      collect(0, -1);
      for (int r = 0; r < 3; r++) begin
         n_checks++; if (got_data[r] !== exp) begin n_fail++; $display("FAIL sgnff_row%0d got %0h want %0h", r, got_data[r], exp); end
      end
   endtask

   task automatic test_reset_mid_out();
      bit ok;
      int n = 0;
      load_a({9{8'h11}});
      send_vector(24'h123456, ok);
      res_ready = 1'b0;
      while (!res_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      n_checks++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL rstout_reach_out got %b want 1", res_valid); end
      rst = 1'b0;
      #1;
      n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL rstout_res_valid got %b want 0", res_valid); end
      n_checks++; if (b_ready !== 1'b0) begin n_fail++; $display("FAIL rstout_b_ready got %b want 0", b_ready); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstout_busy got %b want 0", busy); end
      n_checks++; if (res_data !== '0) begin n_fail++; $display("FAIL rstout_res_data got %0h want 0", res_data); end
      @(negedge clk);
      rst = 1'b1;
      repeat (4) @(negedge clk);
      n_checks++; if (b_ready !== 1'b0) begin n_fail++; $display("FAIL rstout_no_a_b_ready got %b want 0", b_ready); end
      load_a({9{8'h01}});
      n_checks++; if (b_ready !== 1'b1) begin n_fail++; $display("FAIL rstout_reload_b_ready got %b want 1", b_ready); end
   endtask

   initial begin
      test_reset();
      test_identity();
      test_all_ones();
      test_backpressure();
      test_reload_mid_vector();
      test_random();
      test_signed();
      test_reset_mid_out();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
